// File: rtl/perf_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : perf_monitor_if
// Description : Event-strobe inputs and counter outputs of perf_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface perf_monitor_if #(
    parameter int CYCLE_W  = 32,
    parameter int INSN_W   = 32,
    parameter int RETIRE_W = 3,
    parameter int NUM_EVT  = 4,
    parameter int EVT_W    = 16
);
    logic                     halt;
    logic [RETIRE_W-1:0]      retire;
    logic [NUM_EVT-1:0]       evt;
    logic                     freeze;
    logic                     clear;
    logic [CYCLE_W-1:0]       cycle;
    logic [INSN_W-1:0]        insn_count;
    logic [NUM_EVT*EVT_W-1:0] evt_counts;
    logic [1:0]               state;
    logic                     done;
    logic                     timeout;
    logic                     ovf;

    modport master (
        output halt, retire, evt, freeze, clear,
        input  cycle, insn_count, evt_counts, state, done, timeout, ovf
    );

    modport slave (
        input  halt, retire, evt, freeze, clear,
        output cycle, insn_count, evt_counts, state, done, timeout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : perf_monitor
// Description : Saturating cycle / retired-instruction / event counters with
//               halt and cycle-limit termination.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_monitor #(
    parameter int CYCLE_W    = 32,
    parameter int INSN_W     = 32,
    parameter int RETIRE_W   = 3,
    parameter int NUM_EVT    = 4,
    parameter int EVT_W      = 16,
    parameter int MAX_CYCLES = 100000
) (
    input  wire logic     clk,
    input  wire logic     reset,
    perf_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_HALTED  = 2'd1,
        S_TIMEOUT = 2'd2
    } state_t;

    localparam logic [CYCLE_W:0] c_max_cycles = (CYCLE_W+1)'(MAX_CYCLES);
    localparam bit               c_limit_en   = (MAX_CYCLES != 0);

    state_t                         r_state;
    logic [CYCLE_W-1:0]             r_cycle;
    logic [INSN_W-1:0]              r_insn;
    logic [NUM_EVT-1:0][EVT_W-1:0]  r_evt;
    logic                           r_done;
    logic                           r_timeout;
    logic                           r_ovf;

    logic                           w_count;
    logic [CYCLE_W:0]               w_cycle_sum;
    logic [CYCLE_W-1:0]             w_cycle_next;
    logic                           w_limit;
    logic [INSN_W:0]                w_insn_sum;
    logic [INSN_W-1:0]              w_insn_next;
    logic [NUM_EVT-1:0][EVT_W-1:0]  w_evt_next;
    logic [NUM_EVT-1:0]             w_evt_ovf;
    logic                           w_ovf_any;

    assign w_count = (r_state == S_RUN) && !bus.freeze;

    // One extra carry bit on each adder flags the edge that would exceed all-ones.
    assign w_cycle_sum  = {1'b0, r_cycle} + (CYCLE_W+1)'(1);
    assign w_cycle_next = w_cycle_sum[CYCLE_W] ? {CYCLE_W{1'b1}} : w_cycle_sum[CYCLE_W-1:0];
    assign w_limit      = c_limit_en && (w_cycle_sum == c_max_cycles);

    assign w_insn_sum  = {1'b0, r_insn} + {{(INSN_W+1-RETIRE_W){1'b0}}, bus.retire};
    assign w_insn_next = w_insn_sum[INSN_W] ? {INSN_W{1'b1}} : w_insn_sum[INSN_W-1:0];

    generate
        for (genvar i = 0; i < NUM_EVT; i++) begin : g_evt
            logic [EVT_W:0] w_sum;
            assign w_sum         = {1'b0, r_evt[i]} + {{EVT_W{1'b0}}, bus.evt[i]};
            assign w_evt_next[i] = w_sum[EVT_W] ? {EVT_W{1'b1}} : w_sum[EVT_W-1:0];
            assign w_evt_ovf[i]  = w_sum[EVT_W];
        end
    endgenerate

    assign w_ovf_any = w_cycle_sum[CYCLE_W] | w_insn_sum[INSN_W] | (|w_evt_ovf);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_RUN;
            r_cycle   <= '0;
            r_insn    <= '0;
            r_evt     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (bus.clear) begin
            r_state   <= S_RUN;
            r_cycle   <= '0;
            r_insn    <= '0;
            r_evt     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (w_count) begin
                r_cycle <= w_cycle_next;
                r_insn  <= w_insn_next;
                r_evt   <= w_evt_next;
                if (w_ovf_any) begin
                    r_ovf <= 1'b1;
                end
            end
            // Halt outranks the cycle limit when both land on the same edge.
            if (bus.halt) begin
                r_state <= S_HALTED;
                r_done  <= 1'b1;
            end else if (w_count && w_limit) begin
                r_state   <= S_TIMEOUT;
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.cycle      = r_cycle;
    assign bus.insn_count = r_insn;
    assign bus.evt_counts = r_evt;
    assign bus.state      = r_state;
    assign bus.done       = r_done;
    assign bus.timeout    = r_timeout;
    assign bus.ovf        = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_monitor
// Description : Directed scoreboard bench for perf_monitor (main + narrow DUT).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_monitor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    perf_monitor_if #(.CYCLE_W(32), .INSN_W(32), .RETIRE_W(3), .NUM_EVT(4), .EVT_W(4)) bus_m ();
    perf_monitor_if #(.CYCLE_W(4),  .INSN_W(4),  .RETIRE_W(3), .NUM_EVT(4), .EVT_W(4)) bus_s ();

    perf_monitor #(.CYCLE_W(32), .INSN_W(32), .RETIRE_W(3), .NUM_EVT(4), .EVT_W(4),
                   .MAX_CYCLES(50)) dut_m (.clk(clk), .reset(reset), .bus(bus_m));
    perf_monitor #(.CYCLE_W(4),  .INSN_W(4),  .RETIRE_W(3), .NUM_EVT(4), .EVT_W(4),
                   .MAX_CYCLES(0))  dut_s (.clk(clk), .reset(reset), .bus(bus_s));

    typedef struct {
        string       name;
        int          dut;
        logic [31:0] cyc;
        logic [31:0] insn;
        logic [15:0] evts;
        logic [1:0]  st;
        logic        done;
        logic        to;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string n, input int d, input logic [31:0] c, input logic [31:0] i,
                        input logic [15:0] ev, input logic [1:0] s, input logic dn,
                        input logic t, input logic o);
        exp_t e;
        e.name = n; e.dut = d; e.cyc = c; e.insn = i; e.evts = ev;
        e.st = s; e.done = dn; e.to = t; e.ovf = o;
        sb.push_back(e);
    endtask

    // Monitor: outputs are registered, so compare mid-cycle on the falling edge.
    exp_t        m_e;
    logic [84:0] m_act;
    logic [84:0] m_req;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            if (m_e.dut == 0)
                m_act = {bus_m.cycle, bus_m.insn_count, bus_m.evt_counts, bus_m.state,
                         bus_m.done, bus_m.timeout, bus_m.ovf};
            else
                m_act = {28'd0, bus_s.cycle, 28'd0, bus_s.insn_count, bus_s.evt_counts,
                         bus_s.state, bus_s.done, bus_s.timeout, bus_s.ovf};
            m_req = {m_e.cyc, m_e.insn, m_e.evts, m_e.st, m_e.done, m_e.to, m_e.ovf};
            checks++;
            if (m_act !== m_req) begin
                errors++;
                $display("FAIL %s: actual cyc=%0d insn=%0d evt=%h st=%0d done=%b to=%b ovf=%b ; required cyc=%0d insn=%0d evt=%h st=%0d done=%b to=%b ovf=%b",
                         m_e.name, m_act[84:53], m_act[52:21], m_act[20:5], m_act[4:3],
                         m_act[2], m_act[1], m_act[0], m_e.cyc, m_e.insn, m_e.evts,
                         m_e.st, m_e.done, m_e.to, m_e.ovf);
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: actual time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        reset = 1'b1;
        bus_m.halt = 0; bus_m.retire = 0; bus_m.evt = 0; bus_m.freeze = 0; bus_m.clear = 0;
        bus_s.halt = 0; bus_s.retire = 0; bus_s.evt = 0; bus_s.freeze = 0; bus_s.clear = 0;
        repeat (2) tick();
        push("reset_m", 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        push("reset_s", 1, 0, 0, 16'h0000, 0, 0, 0, 0);
        reset = 1'b0;

        // Run then halt on the 11th edge; terminal state ignores random inputs.
        bus_m.retire = 3'd2; bus_m.evt = 4'b0001;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 5) push("run5", 0, 5, 10, 16'h0005, 0, 0, 0, 0);
        end
        bus_m.halt = 1;
        tick();
        push("halt11", 0, 11, 22, 16'h000B, 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            bus_m.halt   = 1'($urandom_range(0, 1));
            bus_m.freeze = 1'($urandom_range(0, 1));
            bus_m.retire = 3'($urandom_range(0, 7));
            bus_m.evt    = 4'($urandom_range(0, 15));
            tick();
            if (i % 5 == 4) push("halt_hold", 0, 11, 22, 16'h000B, 1, 1, 0, 0);
        end

        // Clear together with halt from HALTED.
        bus_m.clear = 1; bus_m.halt = 1; bus_m.freeze = 0; bus_m.retire = 3'd2; bus_m.evt = 4'hF;
        tick();
        push("clr_halt", 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        bus_m.clear = 0; bus_m.halt = 0; bus_m.retire = 3'd1; bus_m.evt = 4'h0;
        tick();
        push("resume", 0, 1, 1, 16'h0000, 0, 0, 0, 0);

        // Freeze during edges 6..10 of 20.
        bus_m.clear = 1;
        tick();
        bus_m.clear = 0; bus_m.retire = 3'd3; bus_m.evt = 4'hF;
        for (int i = 0; i < 20; i++) begin
            bus_m.freeze = (i >= 5 && i <= 9);
            tick();
            if (i == 9) push("frz_mid", 0, 5, 15, 16'h5555, 0, 0, 0, 0);
        end
        push("frz_end", 0, 15, 45, 16'hFFFF, 0, 0, 0, 0);
        bus_m.freeze = 1; bus_m.halt = 1;
        tick();
        push("frz_halt", 0, 15, 45, 16'hFFFF, 1, 1, 0, 0);
        bus_m.freeze = 0; bus_m.halt = 0;

        // Event counter saturation on channel 2.
        bus_m.clear = 1;
        tick();
        bus_m.clear = 0; bus_m.retire = 3'd0; bus_m.evt = 4'b0100;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 15) push("evt_sat15", 0, 15, 0, 16'h0F00, 0, 0, 0, 0);
            if (i == 16) push("evt_ovf16", 0, 16, 0, 16'h0F00, 0, 0, 0, 1);
            if (i == 20) push("evt_hold20", 0, 20, 0, 16'h0F00, 0, 0, 0, 1);
        end
        bus_m.clear = 1; bus_m.evt = 4'h0;
        tick();
        push("clr_ovf", 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        bus_m.clear = 0;

        // Cycle limit of 50.
        bus_m.retire = 3'd1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (i == 49) push("pre_limit", 0, 49, 49, 16'h0000, 0, 0, 0, 0);
            if (i == 50) push("timeout50", 0, 50, 50, 16'h0000, 2, 1, 1, 0);
        end
        bus_m.retire = 3'd7; bus_m.evt = 4'hF; bus_m.halt = 1;
        repeat (5) tick();
        push("to_hold", 0, 50, 50, 16'h0000, 2, 1, 1, 0);
        bus_m.halt = 0; bus_m.evt = 4'h0; bus_m.retire = 3'd1; bus_m.clear = 1;
        tick();
        bus_m.clear = 0;
        for (int i = 1; i <= 50; i++) begin
            bus_m.halt = (i == 50);
            tick();
        end
        push("halt_at_limit", 0, 50, 50, 16'h0000, 1, 1, 0, 0);
        bus_m.halt = 0;

        // Narrow DUT: instruction clamp, then cycle clamp with the limit disabled.
        bus_s.clear = 1;
        tick();
        bus_s.clear = 0; bus_s.retire = 3'd7;
        repeat (2) tick();
        push("s_insn14", 1, 2, 14, 16'h0000, 0, 0, 0, 0);
        tick();
        push("s_insn_sat", 1, 3, 15, 16'h0000, 0, 0, 0, 1);
        bus_s.retire = 3'd0; bus_s.clear = 1;
        tick();
        bus_s.clear = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) push("s_cyc15", 1, 15, 0, 16'h0000, 0, 0, 0, 0);
            if (i == 16) push("s_cyc_sat", 1, 15, 0, 16'h0000, 0, 0, 0, 1);
        end

        // Asynchronous reset pulse entirely between two clock edges.
        bus_m.clear = 1;
        tick();
        bus_m.clear = 0; bus_m.retire = 3'd1;
        repeat (37) tick();
        push("pre_rst", 0, 37, 37, 16'h0000, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        tick();
        push("async_rst", 0, 1, 1, 16'h0000, 0, 0, 0, 0);
        tick();
        push("post_rst", 0, 2, 2, 16'h0000, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/perf_monitor.md
Name: perf_monitor

Overview:
- Parametrised performance-counter block for the CPU core; successor to the single cycle/instruction counter.
- Counts cycles, retired instructions (multi-issue retire width) and NUM_EVT independent event channels (e.g. stalls, flushes, mispredicts).
- Stops on core halt or on a programmable cycle limit and holds final values for the bench/top-level to read.
- Sits beside the writeback stage; inputs come from writeback-valid and pipeline event strobes.

Parameters:
CYCLE_W, 32, width of cycle counter
INSN_W, 32, width of retired-instruction counter
RETIRE_W, 3, width of per-cycle retire count input
NUM_EVT, 4, number of event channels
EVT_W, 16, width of each event counter
MAX_CYCLES, 100000, cycle limit that triggers timeout; 0 disables timeout

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
halt  input  1  core halt strobe
retire  input  RETIRE_W  instructions retired this cycle (unsigned)
evt  input  NUM_EVT  per-channel event strobe, one count per asserted cycle
freeze  input  1  level; while high in RUN, all counters hold
clear  input  1  synchronous clear of counters and state
cycle  output  CYCLE_W  cycle count
insn_count  output  INSN_W  retired-instruction count
evt_counts  output  NUM_EVT*EVT_W  packed event counters, channel i at [i*EVT_W +: EVT_W]
state  output  2  0=RUN, 1=HALTED, 2=TIMEOUT
done  output  1  high in HALTED or TIMEOUT
timeout  output  1  high in TIMEOUT only
ovf  output  1  sticky: any counter saturated

Behaviour:
- Reset (async, active-high): all counters 0, state RUN, done=0, timeout=0, ovf=0. Counting starts on the first posedge after reset deasserts.
- All outputs are registered.
- RUN with freeze=0, at each posedge:
  - cycle += 1
  - insn_count += retire, zero-extended
  - evt counter i += 1 if evt[i]
- RUN with freeze=1: all counters hold; halt and the cycle limit are still evaluated.
- Halt: halt=1 sampled in RUN moves state to HALTED on that edge. That edge's increments still apply unless freeze=1. done=1 from the same edge.
- Timeout (MAX_CYCLES != 0): if the counting edge would make cycle equal MAX_CYCLES, cycle is set to MAX_CYCLES and state moves to TIMEOUT; done=1 and timeout=1.
- halt and the limit on the same edge: HALTED wins, timeout stays 0.
- HALTED and TIMEOUT are terminal. Counters freeze, and halt, retire, evt and freeze are ignored. Only clear or reset leaves these states.
- clear (synchronous, highest priority after reset):
  - all counters and ovf go to 0, state goes to RUN, done=0, timeout=0.
  - Inputs on that edge are not counted.
  - clear together with halt leaves state RUN.
- Saturation: each counter clamps at all-ones; it never wraps. ovf is set on the edge any counter would exceed its maximum and stays set until clear or reset.
  - insn_count near max: a sum larger than 2^INSN_W-1 clamps to 2^INSN_W-1.
- Width rules: RETIRE_W <= INSN_W. Event channels are independent; several may increment on one edge.
- CPI is not computed in hardware; the bench derives it from cycle and insn_count once done=1.

Test Plan:
- Reset, then 10 cycles with retire=2, evt=4'b0001, then halt=1 on the 11th edge → state=1, done=1, cycle=11, insn_count=22, evt ch0=11, other channels 0. Values hold for 20 more cycles with random inputs.
- MAX_CYCLES=50, retire=1, no halt → at edge 50: cycle=50, insn_count=50, state=2, timeout=1; values then hold. Repeat with halt asserted on edge 50 → state=1, timeout=0.
- freeze high for cycles 5–9 of 20 with retire=3, evt=4'b1111 → cycle=15, insn_count=45, each event counter=15. Halt asserted during freeze still yields state=1 with no increment on that edge.
- EVT_W=4, evt[2] held high for 20 cycles → ch2=15 from edge 15 onward and never wraps; ovf=1 from edge 16; other channels 0.
- After reaching HALTED, pulse clear together with halt=1 → state=0, all counters 0, done=0, ovf=0; counting resumes next edge.
- Assert reset asynchronously mid-cycle with cycle=37 → outputs go to 0 immediately, before the next clk edge; state=0.
